// File: rtl/rand_arb_pkg.sv
// Shared types and constants for the random-digit arbiter.
package rand_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_STEP  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [3:0] DIGIT_MIN     = 4'd1;
    localparam logic [3:0] DIGIT_MAX     = 4'd9;
    localparam logic [3:0] REJECT_THRESH = 4'd8;

    // Map an in-range nibble (0..8) onto a Sudoku digit (1..9).
    function automatic logic [3:0] nib_to_digit(input logic [3:0] nib);
        return nib + DIGIT_MIN;
    endfunction

endpackage

// File: rtl/rand_digit_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back so the nearest one wins.
    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        cand      = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(rr_ptr) + i) % int'(NUM_REQ));
            if (req[cand]) begin
                grant_idx = cand;
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rand_digit_arbiter.sv
// Round-robin sequencer for the shared LFSR: steps it, rejection-samples a digit 1..9.
// Optional retry limit with fallback digit: define RAND_ARB_RETRY_LIMIT_EN.
module rand_digit_arbiter
    import rand_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned GEN_LAT   = 2
`ifdef RAND_ARB_RETRY_LIMIT_EN
    ,
    parameter int unsigned MAX_RETRY = 15
`endif
) (
    input  logic               clka,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [3:0]         rand_nib,
    output logic               gen_rand_flag,
    output logic [NUM_REQ-1:0] ack,
    output logic [3:0]         digit,
    output logic               busy,
    output logic               fallback
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 3;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         digit_q, digit_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               flag_q, flag_d;
    logic               busy_q, busy_d;
    logic               fallback_q, fallback_d;
`ifdef RAND_ARB_RETRY_LIMIT_EN
    logic [3:0]         retry_q, retry_d;
`endif

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               accept;
    logic               forced;
    logic [3:0]         new_digit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (pick_idx),
        .any_req   (pick_any)
    );

    // Next-state and registered-output logic; ack/digit are staged from CHECK so they appear in DONE.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        digit_d    = digit_q;
        ack_d      = '0;
        flag_d     = 1'b0;
        fallback_d = 1'b0;
        accept     = 1'b0;
        forced     = 1'b0;
        new_digit  = nib_to_digit(rand_nib);
`ifdef RAND_ARB_RETRY_LIMIT_EN
        retry_d    = retry_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    flag_d  = 1'b1;
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                cnt_d   = CNT_W'(GEN_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_CHECK;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_CHECK: begin
                if (rand_nib <= REJECT_THRESH) begin
                    accept = 1'b1;
                end else begin
`ifdef RAND_ARB_RETRY_LIMIT_EN
                    if (retry_q == 4'(MAX_RETRY)) begin
                        accept    = 1'b1;
                        forced    = 1'b1;
                        new_digit = rand_nib - DIGIT_MAX + DIGIT_MIN;
                    end else begin
                        retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                    end
`endif
                end
                if (accept) begin
                    state_d = ST_DONE;
                    if (req[grant_q]) begin
                        ack_d[grant_q] = 1'b1;
                        digit_d        = new_digit;
                        fallback_d     = forced;
                    end
                end else begin
                    flag_d  = 1'b1;
                    state_d = ST_STEP;
                end
            end
            ST_DONE: begin
                rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
`ifdef RAND_ARB_RETRY_LIMIT_EN
                retry_d  = 4'd0;
`endif
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            digit_q    <= 4'd0;
            ack_q      <= '0;
            flag_q     <= 1'b0;
            busy_q     <= 1'b0;
            fallback_q <= 1'b0;
`ifdef RAND_ARB_RETRY_LIMIT_EN
            retry_q    <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            ack_q      <= ack_d;
            flag_q     <= flag_d;
            busy_q     <= busy_d;
            fallback_q <= fallback_d;
`ifdef RAND_ARB_RETRY_LIMIT_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign gen_rand_flag = flag_q;
    assign ack           = ack_q;
    assign digit         = digit_q;
    assign busy          = busy_q;
    assign fallback      = fallback_q;

endmodule

// File: tb/tb_rand_digit_arbiter.sv
// Directed self-checking bench for rand_digit_arbiter (cycle 0 = first cycle req is seen in IDLE).
module tb_rand_digit_arbiter;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned GEN_LAT = 2;

    logic               clka;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic [3:0]         rand_nib;
    logic               gen_rand_flag;
    logic [NUM_REQ-1:0] ack;
    logic [3:0]         digit;
    logic               busy;
    logic               fallback;

    int n_tests = 0;
    int n_fail  = 0;

    rand_digit_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GEN_LAT (GEN_LAT)
    ) dut (
        .clka          (clka),
        .reset         (reset),
        .req           (req),
        .rand_nib      (rand_nib),
        .gen_rand_flag (gen_rand_flag),
        .ack           (ack),
        .digit         (digit),
        .busy          (busy),
        .fallback      (fallback)
    );

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        rand_nib = 4'd0;
        repeat (2) @(posedge clka);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({gen_rand_flag, ack, digit, busy, fallback} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got flag=%b ack=%b digit=%0d busy=%b fb=%b want all 0",
                     gen_rand_flag, ack, digit, busy, fallback);
        end
    endtask

    task automatic test_single();
        logic [2:0] exp_ack;
        do_reset();
        req      = 3'b001;
        rand_nib = 4'd5;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clka); #1;
            n_tests++;
            if (gen_rand_flag !== 1'(c == 2)) begin
                n_fail++;
                $display("FAIL single_flag c=%0d got %b want %b", c, gen_rand_flag, 1'(c == 2));
            end
            exp_ack = (c == 6) ? 3'b001 : 3'b000;
            n_tests++;
            if (ack !== exp_ack) begin
                n_fail++;
                $display("FAIL single_ack c=%0d got %b want %b", c, ack, exp_ack);
            end
            if (c == 6) begin
                n_tests++;
                if (digit !== 4'd6) begin
                    n_fail++;
                    $display("FAIL single_digit got %0d want 6", digit);
                end
                req = 3'b000;
            end
            if (c == 7) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_busy c=7 got %b want 0", busy);
                end
            end
        end
    endtask

    // One rejection, then acceptance on the second draw.
    task automatic test_reject(input logic [2:0] r, input logic [3:0] n1,
                               input logic [3:0] n2, input logic [3:0] exp_digit);
        logic       exp_flag;
        logic [2:0] exp_ack;
        do_reset();
        req      = r;
        rand_nib = n1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clka); #1;
            exp_flag = (c == 2) || (c == 6);
            n_tests++;
            if (gen_rand_flag !== exp_flag) begin
                n_fail++;
                $display("FAIL reject_flag nib=%0d c=%0d got %b want %b", n1, c, gen_rand_flag, exp_flag);
            end
            exp_ack = (c == 10) ? r : 3'b000;
            n_tests++;
            if (ack !== exp_ack) begin
                n_fail++;
                $display("FAIL reject_ack nib=%0d c=%0d got %b want %b", n1, c, ack, exp_ack);
            end
            if (c == 10) begin
                n_tests++;
                if (digit !== exp_digit) begin
                    n_fail++;
                    $display("FAIL reject_digit nib=%0d got %0d want %0d", n1, digit, exp_digit);
                end
                req = 3'b000;
            end
            if (c == 6) rand_nib = n2;
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_ack;
        do_reset();
        req      = 3'b111;
        rand_nib = 4'd3;
        for (int c = 1; c <= 27; c++) begin
            @(posedge clka); #1;
            case (c)
                6:       exp_ack = 3'b001;
                13:      exp_ack = 3'b010;
                20:      exp_ack = 3'b100;
                27:      exp_ack = 3'b001;
                default: exp_ack = 3'b000;
            endcase
            n_tests++;
            if (ack !== exp_ack) begin
                n_fail++;
                $display("FAIL rotation_ack c=%0d got %b want %b", c, ack, exp_ack);
            end
            if (exp_ack != 3'b000) begin
                n_tests++;
                if (digit !== 4'd4) begin
                    n_fail++;
                    $display("FAIL rotation_digit c=%0d got %0d want 4", c, digit);
                end
            end
        end
        req = 3'b000;
    endtask

    // Runs after rotation (rr_ptr=1); a withdrawn grant of requester 2 must still move rr_ptr to 0.
    task automatic test_withdrawn();
        logic [2:0] exp_ack;
        @(posedge clka); #1;
        req      = 3'b100;
        rand_nib = 4'd7;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clka); #1;
            n_tests++;
            if (ack !== 3'b000) begin
                n_fail++;
                $display("FAIL withdrawn_ack c=%0d got %b want 000", c, ack);
            end
            if (c == 7) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL withdrawn_busy c=7 got %b want 0", busy);
                end
            end
            if (c == 3) req = 3'b000;
        end
        req = 3'b011;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clka); #1;
            exp_ack = (c == 6) ? 3'b001 : 3'b000;
            n_tests++;
            if (ack !== exp_ack) begin
                n_fail++;
                $display("FAIL withdrawn_ptr_ack c=%0d got %b want %b", c, ack, exp_ack);
            end
            if (c == 6) begin
                n_tests++;
                if (digit !== 4'd8) begin
                    n_fail++;
                    $display("FAIL withdrawn_ptr_digit got %0d want 8", digit);
                end
                req = 3'b000;
            end
        end
        req      = 3'b100;
        rand_nib = 4'd8;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clka); #1;
            exp_ack = (c == 6) ? 3'b100 : 3'b000;
            n_tests++;
            if (ack !== exp_ack) begin
                n_fail++;
                $display("FAIL withdrawn_again_ack c=%0d got %b want %b", c, ack, exp_ack);
            end
            if (c == 6) begin
                n_tests++;
                if (digit !== 4'd9) begin
                    n_fail++;
                    $display("FAIL withdrawn_again_digit got %0d want 9", digit);
                end
                req = 3'b000;
            end
        end
    endtask

    task automatic test_reset_mid_draw();
        req      = 3'b001;
        rand_nib = 4'd5;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clka); #1;
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL middraw_busy_before got %b want 1", busy);
        end
        reset = 1'b1;
        req   = 3'b000;
        @(posedge clka); #1;
        n_tests++;
        if ({gen_rand_flag, ack, digit, busy, fallback} !== 10'd0) begin
            n_fail++;
            $display("FAIL middraw_reset got flag=%b ack=%b digit=%0d busy=%b fb=%b want all 0",
                     gen_rand_flag, ack, digit, busy, fallback);
        end
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clka); #1;
            n_tests++;
            if (ack !== 3'b000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL middraw_after c=%0d got ack=%b busy=%b want 000/0", c, ack, busy);
            end
        end
    endtask

    task automatic test_retry_limit();
        int flags;
        int acks;
        int fbs;
        flags = 0;
        acks  = 0;
        fbs   = 0;
        do_reset();
        req      = 3'b001;
        rand_nib = 4'd15;
`ifdef RAND_ARB_RETRY_LIMIT_EN
        for (int c = 1; c <= 70; c++) begin
            @(posedge clka); #1;
            if (c <= 66 && gen_rand_flag === 1'b1) flags++;
            if (c == 66) begin
                n_tests++;
                if (ack !== 3'b001 || digit !== 4'd7 || fallback !== 1'b1 || flags != 16) begin
                    n_fail++;
                    $display("FAIL retry_fallback got ack=%b digit=%0d fb=%b steps=%0d want 001/7/1/16",
                             ack, digit, fallback, flags);
                end
                req = 3'b000;
            end else begin
                n_tests++;
                if (ack !== 3'b000 || fallback !== 1'b0) begin
                    n_fail++;
                    $display("FAIL retry_quiet c=%0d got ack=%b fb=%b want 000/0", c, ack, fallback);
                end
            end
        end
`else
        for (int c = 1; c <= 410; c++) begin
            @(posedge clka); #1;
            if (gen_rand_flag === 1'b1) flags++;
            if (ack !== 3'b000) acks++;
            if (fallback !== 1'b0) fbs++;
        end
        n_tests++;
        if (acks != 0 || fbs != 0 || flags < 100) begin
            n_fail++;
            $display("FAIL retry_unbounded got acks=%0d fallbacks=%0d steps=%0d want 0/0/>=100",
                     acks, fbs, flags);
        end
`endif
        do_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        rand_nib = 4'd0;
        test_reset();
        test_single();
        test_reject(3'b010, 4'd12, 4'd0, 4'd1);
        test_reject(3'b001, 4'd9, 4'd8, 4'd9);
        test_rotation();
        test_withdrawn();
        test_reset_mid_draw();
        test_retry_limit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rand_digit_arbiter.md
# rand_digit_arbiter

Sequencer and round-robin arbiter for the shared LFSR random source in the Sudoku generator. Several requesters (board setup, cell-A filler, cell-B filler) each ask for a random digit 1–9. The block pulses the generator's step flag, waits for the new nibble and rejection-samples it into range. It then returns the digit to exactly one requester per draw, so no two consumers ever see the same LFSR state.

## Interface
- NUM_REQ, 3, number of requesters (2–8)
- GEN_LAT, 2, cycles from step pulse until rand_nib reflects the new LFSR state (1–7)
- MAX_RETRY, 15, rejected draws tolerated per grant before fallback (only with RAND_ARB_RETRY_LIMIT_EN)
- clka  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-requester level request, held until ack
- rand_nib  in  4  nibble from the generator (rand_A field)
- gen_rand_flag  out  1  one-cycle step pulse to the generator
- ack  out  NUM_REQ  one-hot, one-cycle pulse; digit valid in the same cycle
- digit  out  4  result 1–9, held until the next ack
- busy  out  1  high in every state except IDLE
- fallback  out  1  one-cycle pulse with ack when the retry limit forced the result

## Operation
- States: IDLE, ARB, STEP, WAIT, CHECK, DONE.
- IDLE: if any req bit is set, go to ARB. Otherwise stay.
- ARB: the round-robin picker selects the first set req at or after rr_ptr (wrapping) and registers grant_idx, then goes to STEP. If req has gone all-zero, return to IDLE.
- STEP: gen_rand_flag=1 for exactly this cycle. Load the wait counter with GEN_LAT-1 and go to WAIT.
- WAIT: decrement the counter and go to CHECK at zero.
- CHECK: sample rand_nib.
  - If rand_nib ≤ 8, store digit_next = rand_nib+1 and go to DONE.
  - Otherwise increment the retry counter (4-bit, saturating) and go to STEP.
- DONE: if req[grant_idx] is still high, pulse ack[grant_idx] and update digit. If it dropped, discard the result with no ack. In both cases set rr_ptr = grant_idx+1 mod NUM_REQ, clear the retry counter and go to IDLE.
- Requests arriving mid-draw wait. Only one draw is in flight at a time.
- req bits outside NUM_REQ do not exist. Requesters with the same priority are served strictly in rotation.
- Reset (at any state, including mid-draw): state=IDLE, rr_ptr=0, retry=0, digit=4'd0, ack=0, gen_rand_flag=0, busy=0, fallback=0. The draw in progress is abandoned with no ack.

## Timing
- req first sampled high in IDLE at cycle 0:
  - ARB at 1
  - STEP (gen_rand_flag) at 2
  - WAIT at 3..2+GEN_LAT
  - CHECK at 3+GEN_LAT
  - ack at 4+GEN_LAT (6 cycles for the default)
- Each rejection adds 2+GEN_LAT cycles.
- After ack the block is in IDLE for one cycle. Back-to-back requests are therefore separated by at least 5+GEN_LAT cycles.
- All outputs are registered. No combinational path exists from req or rand_nib to any output.

## Configuration
- RAND_ARB_RETRY_LIMIT_EN defined:
  - When CHECK rejects and the retry count already equals MAX_RETRY, accept anyway with digit = (rand_nib − 9) + 1, range 1–7.
  - fallback pulses with ack.
- Undefined:
  - Retries are unbounded and fallback is tied to 0.
  - The retry counter and MAX_RETRY compare are not built.

## Structure
- Package rand_arb_pkg:
  - state enum typedef
  - DIGIT_MIN=1, DIGIT_MAX=9 and REJECT_THRESH=8 constants
- Sub-module rr_pick: combinational round-robin picker taking req and rr_ptr, returning grant_idx and any_req. It is parameterised by NUM_REQ.

## Test plan
- Single request: req=3'b001, rand_nib=4'd5 → gen_rand_flag one pulse at cycle 2, ack=3'b001 at cycle 6, digit=6, busy low at cycle 7.
- Rejection: req=3'b010, rand_nib=4'd12 on first CHECK then 4'd0 → two gen_rand_flag pulses, ack=3'b010 at cycle 10, digit=1.
- Rotation: req=3'b111 held continuously, rand_nib=4'd3 → acks in order 001, 010, 100, 001, digit=4 each.
- Withdrawn request: req=3'b100 dropped at cycle 4 → no ack, rr_ptr=0. A following req=3'b100 is still served.
- Reset mid-draw: reset asserted during WAIT → next cycle all outputs 0 and state IDLE, with no ack ever issued for that draw.
- Retry limit (macro defined, MAX_RETRY=15): rand_nib held at 4'd15 → 16 step pulses, then ack with digit=7 and fallback=1. Macro undefined: no ack for 100 draws and fallback stays 0.
